vit_dec_bmc_depunct: RTL and testbench

//  Next-generation Viterbi branch metric calculator with a built-in depuncturer and ready/valid flow control.

---
 rtl/vit_dec_bmc_depunct.sv | 185 ++++++++++++++++++
 tb/tb_vit_dec_bmc_depunct.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vit_dec_bmc_depunct.sv
// Viterbi branch metric calculator with built-in depuncturer.
// Serial LLRs are assembled into N-bit trellis steps and all 2^N branch metrics are emitted per step.
module vit_dec_bmc_depunct #(
    parameter int pCODE_GEN_NUM = 2,
    parameter int pLLR_W        = 4,
    parameter int pTAG_W        = 4,
    parameter int pHD_MODE      = 0,
    parameter int pPUNCT_PERIOD = 1,
    parameter logic [pPUNCT_PERIOD*pCODE_GEN_NUM-1:0] pPUNCT_MASK = '1,
    localparam int cN   = pCODE_GEN_NUM,
    localparam int cK   = 2**pCODE_GEN_NUM,
    localparam int cBMW = (pHD_MODE != 0) ? $clog2(pCODE_GEN_NUM+1) : pLLR_W + $clog2(pCODE_GEN_NUM)
)(
    input  logic                      iclk,
    input  logic                      ireset_n,
    input  logic                      iclkena,
    input  logic                      isop,
    input  logic                      ival,
    input  logic                      ieop,
    input  logic [pTAG_W-1:0]         itag,
    input  logic [pLLR_W-1:0]         iLLR,
    output logic                      ordy,
    input  logic                      iordy,
    output logic                      osop,
    output logic                      oval,
    output logic                      oeop,
    output logic [pTAG_W-1:0]         otag,
    output logic [cN-1:0]             ohd,
    output logic [cN-1:0]             oera,
    output logic [cK-1:0][cBMW-1:0]   obm,
    output logic                      oabort
);

    localparam int cSW = (pPUNCT_PERIOD > 1) ? $clog2(pPUNCT_PERIOD) : 1;
    localparam int cPW = $clog2(cN);

    for (genvar g = 0; g < pPUNCT_PERIOD; g++) begin : g_mask_chk
        if (pPUNCT_MASK[g*cN +: cN] == '0) begin : g_bad
            $error("vit_dec_bmc_depunct: puncture step %0d has no transmitted position", g);
        end
    end

    function automatic logic mask_at(input int st, input int i);
        logic [pPUNCT_PERIOD*cN-1:0] sh;
        sh = pPUNCT_MASK >> (st*cN + i);
        return sh[0];
    endfunction

    function automatic logic [cPW-1:0] first_pos(input int st);
        first_pos = '0;
        for (int i = cN-1; i >= 0; i--)
            if (mask_at(st, i)) first_pos = cPW'(i);
    endfunction

    function automatic logic [cPW-1:0] next_pos(input int st, input int pos);
        next_pos = cPW'(pos);
        for (int i = cN-1; i >= 0; i--)
            if (i > pos && mask_at(st, i)) next_pos = cPW'(i);
    endfunction

    function automatic logic is_last(input int st, input int pos);
        is_last = 1'b1;
        for (int i = 0; i < cN; i++)
            if (i > pos && mask_at(st, i)) is_last = 1'b0;
    endfunction

    logic [cSW-1:0]              s_q, s_d, cur_s;
    logic [cPW-1:0]              pos_q, pos_d, cur_pos;
    logic [cN-1:0][pLLR_W-1:0]   llr_q, llr_d, cur_llr;
    logic [cN-1:0]               wr_q, wr_d, cur_wr;
    logic                        sop_pend_q, sop_pend_d, cur_sop;
    logic [pTAG_W-1:0]           tag_q, tag_d, cur_tag;
    logic                        oval_q, oval_d, osop_q, osop_d, oeop_q, oeop_d, oabort_q, oabort_d;
    logic [pTAG_W-1:0]           otag_q, otag_d;
    logic [cN-1:0]               ohd_q, ohd_d, oera_q, oera_d, hd_c;
    logic [cK-1:0][cBMW-1:0]     obm_q, obm_d, bm_c;
    logic                        accept, complete;
    logic [pLLR_W-1:0]           llr_sat;

    assign ordy    = !oval_q || iordy;
    assign accept  = ival && ordy && iclkena;
    // The most negative code has no positive twin, so clamp it to keep the metrics symmetric.
    assign llr_sat = (iLLR == {1'b1, {(pLLR_W-1){1'b0}}}) ? {1'b1, {(pLLR_W-2){1'b0}}, 1'b1} : iLLR;

    always_comb begin
        cur_s = s_q;  cur_pos = pos_q;  cur_llr = llr_q;  cur_wr = wr_q;
        cur_sop = sop_pend_q;  cur_tag = tag_q;
        s_d = s_q;  pos_d = pos_q;  llr_d = llr_q;  wr_d = wr_q;
        sop_pend_d = sop_pend_q;  tag_d = tag_q;
        complete = 1'b0;
        oabort_d = 1'b0;
        if (accept) begin
            if (isop) begin
                oabort_d = |wr_q;
                cur_s = '0;  cur_pos = first_pos(0);  cur_llr = '0;  cur_wr = '0;
                cur_sop = 1'b1;  cur_tag = itag;
            end
            cur_llr[cur_pos] = llr_sat;
            cur_wr[cur_pos]  = 1'b1;
            complete = ieop || is_last(int'(cur_s), int'(cur_pos));
            tag_d = cur_tag;
            if (complete) begin
                llr_d = '0;  wr_d = '0;  sop_pend_d = 1'b0;
                if (ieop || cur_s == cSW'(pPUNCT_PERIOD-1)) begin
                    s_d = '0;  pos_d = first_pos(0);
                end else begin
                    s_d = cur_s + cSW'(1);  pos_d = first_pos(int'(cur_s) + 1);
                end
            end else begin
                llr_d = cur_llr;  wr_d = cur_wr;  sop_pend_d = cur_sop;
                s_d = cur_s;  pos_d = next_pos(int'(cur_s), int'(cur_pos));
            end
        end
    end

    always_comb begin
        for (int i = 0; i < cN; i++)
            hd_c[i] = cur_wr[i] & ~cur_llr[i][pLLR_W-1];
    end

    if (pHD_MODE != 0) begin : g_hard
        logic [cN-1:0] kb;
        always_comb begin
            kb   = '0;
            bm_c = '0;
            for (int k = 0; k < cK; k++) begin
                kb = cN'(k);
                for (int i = 0; i < cN; i++)
                    if (cur_wr[i] && (kb[i] != hd_c[i])) bm_c[k] = bm_c[k] + cBMW'(1);
            end
        end
    end else begin : g_soft
        logic [cN-1:0]   kb;
        logic [cBMW-1:0] ext, sum;
        always_comb begin
            kb   = '0;
            ext  = '0;
            sum  = '0;
            bm_c = '0;
            for (int k = 0; k < cK; k++) begin
                kb  = cN'(k);
                sum = '0;
                for (int i = 0; i < cN; i++) begin
                    ext = {{(cBMW-pLLR_W){cur_llr[i][pLLR_W-1]}}, cur_llr[i]};
                    sum = kb[i] ? sum + ext : sum - ext;
                end
                bm_c[k] = sum;
            end
        end
    end

    always_comb begin
        oval_d = oval_q;  osop_d = osop_q;  oeop_d = oeop_q;  otag_d = otag_q;
        ohd_d = ohd_q;  oera_d = oera_q;  obm_d = obm_q;
        if (oval_q && iordy) oval_d = 1'b0;
        if (complete) begin
            oval_d = 1'b1;  osop_d = cur_sop;  oeop_d = ieop;  otag_d = cur_tag;
            ohd_d = hd_c;  oera_d = ~cur_wr;  obm_d = bm_c;
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            s_q <= '0;  pos_q <= first_pos(0);  llr_q <= '0;  wr_q <= '0;
            sop_pend_q <= 1'b0;  tag_q <= '0;
            oval_q <= 1'b0;  osop_q <= 1'b0;  oeop_q <= 1'b0;  oabort_q <= 1'b0;
            otag_q <= '0;  ohd_q <= '0;  oera_q <= '0;  obm_q <= '0;
        end else if (iclkena) begin
            s_q <= s_d;  pos_q <= pos_d;  llr_q <= llr_d;  wr_q <= wr_d;
            sop_pend_q <= sop_pend_d;  tag_q <= tag_d;
            oval_q <= oval_d;  osop_q <= osop_d;  oeop_q <= oeop_d;  oabort_q <= oabort_d;
            otag_q <= otag_d;  ohd_q <= ohd_d;  oera_q <= oera_d;  obm_q <= obm_d;
        end
    end

    assign oval   = oval_q;
    assign osop   = osop_q;
    assign oeop   = oeop_q;
    assign oabort = oabort_q;
    assign otag   = otag_q;
    assign ohd    = ohd_q;
    assign oera   = oera_q;
    assign obm    = obm_q;

endmodule

// File: tb/tb_vit_dec_bmc_depunct.sv
// Bench for vit_dec_bmc_depunct: a soft and a hard instance share one stimulus stream
// (N=2, W=4, P=2, mask 4'b0111) and are compared against a step-level reference model.
module tb_vit_dec_bmc_depunct;

    localparam int N = 2, W = 4, TW = 4, P = 2, K = 4;
    localparam logic [3:0] MASK = 4'b0111;
    localparam int BMW_S = 5, BMW_H = 2;

    logic iclk = 1'b0, ireset_n = 1'b0, iclkena = 1'b1;
    logic isop = 1'b0, ival = 1'b0, ieop = 1'b0, iordy = 1'b1;
    logic [TW-1:0] itag = '0;
    logic [W-1:0]  iLLR = '0;

    logic ordy_s, osop_s, oval_s, oeop_s, oabort_s;
    logic ordy_h, osop_h, oval_h, oeop_h, oabort_h;
    logic [TW-1:0] otag_s, otag_h;
    logic [N-1:0]  ohd_s, oera_s, ohd_h, oera_h;
    logic [K-1:0][BMW_S-1:0] obm_s;
    logic [K-1:0][BMW_H-1:0] obm_h;

    int n_vec = 0, n_err = 0;

    always #5 iclk = ~iclk;

    vit_dec_bmc_depunct #(.pCODE_GEN_NUM(N), .pLLR_W(W), .pTAG_W(TW), .pHD_MODE(0),
                          .pPUNCT_PERIOD(P), .pPUNCT_MASK(MASK)) dut_soft (
        .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena), .isop(isop), .ival(ival),
        .ieop(ieop), .itag(itag), .iLLR(iLLR), .ordy(ordy_s), .iordy(iordy),
        .osop(osop_s), .oval(oval_s), .oeop(oeop_s), .otag(otag_s), .ohd(ohd_s),
        .oera(oera_s), .obm(obm_s), .oabort(oabort_s));

    vit_dec_bmc_depunct #(.pCODE_GEN_NUM(N), .pLLR_W(W), .pTAG_W(TW), .pHD_MODE(1),
                          .pPUNCT_PERIOD(P), .pPUNCT_MASK(MASK)) dut_hard (
        .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena), .isop(isop), .ival(ival),
        .ieop(ieop), .itag(itag), .iLLR(iLLR), .ordy(ordy_h), .iordy(iordy),
        .osop(osop_h), .oval(oval_h), .oeop(oeop_h), .otag(otag_h), .ohd(ohd_h),
        .oera(oera_h), .obm(obm_h), .oabort(oabort_h));

    // Reference model: LLRs of the current step are queued; when the step's transmitted
    // count is reached (or eop arrives) the expected output word is built from them.
    int m_s = 0;
    int m_items[$];
    bit m_sop = 0;
    int m_tag = 0;
    bit e_oval = 0, e_osop = 0, e_oeop = 0, e_oabort = 0;
    int e_otag = 0, e_ohd = 0, e_oera = 0;
    int e_soft[K] = '{0, 0, 0, 0};
    int e_hard[K] = '{0, 0, 0, 0};

    function automatic bit txAt(input int st, input int i);
        return ((MASK >> (st*N + i)) & 4'd1) != 4'd0;
    endfunction

    function automatic int txCount(input int st);
        int c = 0;
        for (int i = 0; i < N; i++) if (txAt(st, i)) c++;
        return c;
    endfunction

    function automatic int sat(input logic [W-1:0] v);
        int x;
        x = int'($signed(v));
        return (x == -8) ? -7 : x;
    endfunction

    task automatic modelReset();
        m_s = 0; m_items.delete(); m_sop = 0; m_tag = 0;
        e_oval = 0; e_osop = 0; e_oeop = 0; e_oabort = 0;
        e_otag = 0; e_ohd = 0; e_oera = 0;
        for (int k = 0; k < K; k++) begin e_soft[k] = 0; e_hard[k] = 0; end
    endtask

    task automatic emitStep(input bit eop);
        int tx[$];
        int L[N];
        bit wr[N];
        int kb;
        for (int i = 0; i < N; i++) begin
            L[i] = 0; wr[i] = 0;
            if (txAt(m_s, i)) tx.push_back(i);
        end
        for (int j = 0; j < m_items.size(); j++) begin
            L[tx[j]] = m_items[j]; wr[tx[j]] = 1;
        end
        e_ohd = 0; e_oera = 0;
        for (int i = 0; i < N; i++) begin
            if (!wr[i]) e_oera |= (1 << i);
            else if (L[i] >= 0) e_ohd |= (1 << i);
        end
        for (int k = 0; k < K; k++) begin
            e_soft[k] = 0; e_hard[k] = 0;
            for (int i = 0; i < N; i++) begin
                kb = (k >> i) & 1;
                e_soft[k] += (kb != 0) ? L[i] : -L[i];
                if (wr[i] && kb != ((e_ohd >> i) & 1)) e_hard[k]++;
            end
        end
        e_oval = 1; e_osop = m_sop; e_oeop = eop; e_otag = m_tag;
        m_sop = 0;
        m_items.delete();
        m_s = eop ? 0 : (m_s + 1) % P;
    endtask

    always @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) modelReset();
        else if (iclkena) begin
            bit acc, abort;
            acc   = ival && (!e_oval || iordy);
            abort = 0;
            if (e_oval && iordy) e_oval = 0;
            if (acc) begin
                if (isop) begin
                    abort = (m_items.size() != 0);
                    m_items.delete(); m_s = 0; m_sop = 1; m_tag = int'(itag);
                end
                m_items.push_back(sat(iLLR));
                if (ieop || m_items.size() == txCount(m_s)) emitStep(ieop);
            end
            e_oabort = abort;
        end
    end

    task automatic checkField(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compares both instances with the model; payload only matters while oval is high.
    task automatic checkOutput();
        int exp_rdy;
        exp_rdy = (!e_oval || iordy) ? 1 : 0;
        checkField("ordy_s", int'(ordy_s), exp_rdy);
        checkField("ordy_h", int'(ordy_h), exp_rdy);
        checkField("oval_s", int'(oval_s), int'(e_oval));
        checkField("oval_h", int'(oval_h), int'(e_oval));
        checkField("oabort_s", int'(oabort_s), int'(e_oabort));
        checkField("oabort_h", int'(oabort_h), int'(e_oabort));
        if (e_oval) begin
            checkField("osop", int'(osop_s), int'(e_osop));
            checkField("oeop", int'(oeop_s), int'(e_oeop));
            checkField("otag", int'(otag_s), e_otag);
            checkField("ohd", int'(ohd_s), e_ohd);
            checkField("oera", int'(oera_s), e_oera);
            checkField("ohd_h", int'(ohd_h), e_ohd);
            checkField("oera_h", int'(oera_h), e_oera);
            for (int k = 0; k < K; k++) begin
                checkField($sformatf("obm_s[%0d]", k), int'($signed(obm_s[k])), e_soft[k]);
                checkField($sformatf("obm_h[%0d]", k), int'(obm_h[k]), e_hard[k]);
            end
        end
    endtask

    // Drives one beat, lets one clock edge pass, then checks at the falling edge.
    task automatic applyStimulus(input logic v, input logic s, input logic e,
                                 input int tag, input int llr, input logic r);
        ival = v; isop = s; ieop = e; itag = TW'(tag); iLLR = W'(llr); iordy = r;
        @(negedge iclk);
        checkOutput();
    endtask

    task automatic checkSoft(input string name, input int b0, input int b1, input int b2, input int b3);
        checkField({name, "_bm0"}, int'($signed(obm_s[0])), b0);
        checkField({name, "_bm1"}, int'($signed(obm_s[1])), b1);
        checkField({name, "_bm2"}, int'($signed(obm_s[2])), b2);
        checkField({name, "_bm3"}, int'($signed(obm_s[3])), b3);
    endtask

    task automatic checkHard(input string name, input int b0, input int b1, input int b2, input int b3);
        checkField({name, "_hbm0"}, int'(obm_h[0]), b0);
        checkField({name, "_hbm1"}, int'(obm_h[1]), b1);
        checkField({name, "_hbm2"}, int'(obm_h[2]), b2);
        checkField({name, "_hbm3"}, int'(obm_h[3]), b3);
    endtask

    initial begin
        ireset_n = 1'b0;
        repeat (3) @(negedge iclk);
        checkField("rst_oval", int'(oval_s), 0);
        checkField("rst_osop", int'(osop_s), 0);
        checkField("rst_oeop", int'(oeop_s), 0);
        checkField("rst_oabort", int'(oabort_s), 0);
        checkField("rst_otag", int'(otag_s), 0);
        checkField("rst_ohd", int'(ohd_s), 0);
        checkField("rst_oera", int'(oera_s), 0);
        checkSoft("rst", 0, 0, 0, 0);
        checkHard("rst", 0, 0, 0, 0);
        checkOutput();
        ireset_n = 1'b1;

        // Full-rate step 0, then single-position step 1
        applyStimulus(1, 1, 0, 5, 3, 1);
        checkField("t1_oval_early", int'(oval_s), 0);
        applyStimulus(1, 0, 0, 5, -2, 1);
        checkField("t1_oval", int'(oval_s), 1);
        checkField("t1_osop", int'(osop_s), 1);
        checkField("t1_otag", int'(otag_s), 5);
        checkField("t1_ohd", int'(ohd_s), 1);
        checkField("t1_oera", int'(oera_s), 0);
        checkSoft("t1", -1, 5, -5, 1);
        checkHard("t1", 1, 0, 2, 1);
        applyStimulus(1, 0, 0, 5, 5, 1);
        checkField("t2_osop", int'(osop_s), 0);
        checkField("t2_oera", int'(oera_s), 2);
        checkSoft("t2", -5, 5, -5, 5);
        checkHard("t2", 1, 0, 1, 0);

        // Saturation of the most negative LLR
        applyStimulus(1, 0, 0, 5, -8, 1);
        applyStimulus(1, 0, 0, 5, -8, 1);
        checkSoft("t3", 14, 0, 0, -14);

        // Backpressure with an output pending
        repeat (5) applyStimulus(1, 0, 0, 5, 2, 0);
        checkField("t4_ordy_low", int'(ordy_s), 0);
        checkField("t4_oval_held", int'(oval_s), 1);
        checkSoft("t4", 14, 0, 0, -14);
        applyStimulus(0, 0, 0, 5, 0, 1);
        checkField("t4_oval_drop", int'(oval_s), 0);
        checkField("t4_ordy_high", int'(ordy_s), 1);

        // Step 1, then eop at position 0 of the full-rate step, then a discarded partial step
        applyStimulus(1, 0, 0, 5, 1, 1);
        checkSoft("t5a", -1, 1, -1, 1);
        checkHard("t6b", 1, 0, 1, 0);
        applyStimulus(1, 0, 1, 5, 4, 1);
        checkField("t5_oeop", int'(oeop_s), 1);
        checkField("t5_oera", int'(oera_s), 2);
        checkSoft("t5", -4, 4, -4, 4);
        applyStimulus(1, 1, 0, 9, 2, 1);
        applyStimulus(1, 1, 0, 10, 1, 1);
        checkField("t5_oabort", int'(oabort_s), 1);
        checkField("t5_no_out", int'(oval_s), 0);
        applyStimulus(1, 0, 0, 10, 2, 1);
        checkField("t6_oabort_clr", int'(oabort_s), 0);
        checkField("t6_ohd", int'(ohd_h), 3);
        checkField("t6_osop", int'(osop_h), 1);
        checkField("t6_otag", int'(otag_h), 10);
        checkHard("t6", 2, 1, 1, 0);
        applyStimulus(0, 0, 0, 10, 0, 1);

        // Randomized traffic with clock-enable gaps and one mid-frame async reset
        for (int c = 0; c < 3000; c++) begin
            int llr;
            iclkena = ($urandom_range(0, 9) != 0);
            if (c == 1500) ireset_n = 1'b0;
            if (c == 1503) ireset_n = 1'b1;
            llr = int'($urandom_range(0, 15)) - 8;
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0,
                          $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)), llr,
                          $urandom_range(0, 9) < 7);
        end
        iclkena = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
